// File: rtl/program_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed byte
// frame, assembles big-endian 32-bit words, writes them to instruction memory
// and releases the CPU from reset only after a clean load.
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
  } state_t;

  // Header count is 16 bits; one extra bit keeps the overflow compare unsigned
  // and exact for every MAX_WORDS up to 65535.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  logic        acc;
  logic [16:0] n_hdr;
  logic [31:0] wr_addr_k;

  assign acc       = rx_valid && rx_ready;
  assign n_hdr     = {1'b0, len_hi, rx_data};
  // Address of the word being completed; plain 32-bit add, wraps silently.
  assign wr_addr_k = ADDR_BASE + {14'd0, word_cnt, 2'b00};

  // Loader FSM with registered handshake, write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= ADDR_BASE;
      imem_wr_data <= 32'd0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      len_hi       <= 8'd0;
      len          <= 16'd0;
      word_cnt     <= 16'd0;
      byte_cnt     <= 2'd0;
      word_buf     <= 24'd0;
      csum         <= 8'd0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold otherwise.
      imem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // rx_ready is low here, so a byte offered with start is not taken.
          if (start) begin
            state    <= LEN_HI;
            rx_ready <= 1'b1;
            word_cnt <= 16'd0;
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
          end
        end
        LEN_HI: begin
          if (acc) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (acc) begin
            len <= n_hdr[15:0];
            if (n_hdr == 17'd0) begin
              state <= CHECK;
            end else if (n_hdr > MAX_N) begin
              state    <= ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= wr_addr_k;
              imem_wr_data <= {word_buf, rx_data};
              word_cnt     <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == len) state <= CHECK;
            end else begin
              word_buf <= {word_buf[15:0], rx_data};
            end
          end
        end
        CHECK: begin
          if (acc) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          // A new start re-arms a fresh session from a terminal state.
          if (start) begin
            state     <= LEN_HI;
            rx_ready  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            word_cnt  <= 16'd0;
            byte_cnt  <= 2'd0;
            csum      <= 8'd0;
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go into a
// scoreboard queue, a negedge monitor pops and compares every write strobe.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_wr_en, cpu_reset, done, error;
  logic [31:0] imem_wr_addr, imem_wr_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // Header 00 02 plus two payload words. Each word XORs to 08, so the
  // checksum over all eight payload bytes is 00.
  logic [7:0] GOOD [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                            8'h9A, 8'hBC, 8'hDE, 8'hF0};

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (imem_wr_en !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h en %b, none expected",
                 imem_wr_addr, imem_wr_data, imem_wr_en);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_wr_addr, imem_wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   imem_wr_addr, imem_wr_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Offer one byte after 'gap' idle cycles; optionally assert reset in the
  // very cycle it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_rst);
    int tries;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    while (rx_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    if (with_rst) reset = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reset    = 1'b0;
  endtask

  function automatic int gap_of(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  task automatic send_good(input logic [7:0] cks, input int maxgap);
    for (int i = 0; i < 10; i++) send_byte(GOOD[i], gap_of(maxgap), 1'b0);
    send_byte(cks, gap_of(maxgap), 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic status(input string tag, input bit d, input bit e, input bit c, input bit r);
    @(negedge clk);
    chk({tag, "_done"},      {31'd0, done},      {31'd0, d});
    chk({tag, "_error"},     {31'd0, error},     {31'd0, e});
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, c});
    chk({tag, "_rx_ready"},  {31'd0, rx_ready},  {31'd0, r});
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  x;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset values, with start and rx_valid high to show reset priority.
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready",  {31'd0, rx_ready},   32'd0);
    chk("rst_wr_en",     {31'd0, imem_wr_en}, 32'd0);
    chk("rst_wr_addr",   imem_wr_addr,        32'h0);
    chk("rst_wr_data",   imem_wr_data,        32'h0);
    chk("rst_cpu_reset", {31'd0, cpu_reset},  32'd1);
    chk("rst_done",      {31'd0, done},       32'd0);
    chk("rst_error",     {31'd0, error},      32'd0);
    start = 1'b0; rx_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", {31'd0, rx_ready},   32'd0);

    // Good load.
    pulse_start();
    push(32'h0, 32'h1234_5678);
    push(32'h4, 32'h9ABC_DEF0);
    send_good(8'h00, 0);
    status("good", 1, 0, 0, 0);
    drain("good");
    chk("hold_addr", imem_wr_addr, 32'h4);
    chk("hold_data", imem_wr_data, 32'h9ABC_DEF0);

    // Restart from DONE and reload from the base address.
    pulse_start();
    chk("restart_done",      {31'd0, done},      32'd0);
    chk("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("restart_rx_ready",  {31'd0, rx_ready},  32'd1);
    push(32'h0, 32'h1234_5678);
    push(32'h4, 32'h9ABC_DEF0);
    send_good(8'h00, 0);
    status("reload", 1, 0, 0, 0);
    drain("reload");

    // Bad checksum.
    pulse_start();
    push(32'h0, 32'h1234_5678);
    push(32'h4, 32'h9ABC_DEF0);
    send_good(8'h09, 0);
    status("badcks", 0, 1, 1, 0);
    drain("badcks");

    // Count overflow (257), entered from ERROR.
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    status("ovf", 0, 1, 1, 0);
    drain("ovf");

    // Zero count: checksum of an empty payload is 00.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    status("zero", 1, 0, 0, 0);
    drain("zero");

    // Gapped stream.
    pulse_start();
    push(32'h0, 32'h1234_5678);
    push(32'h4, 32'h9ABC_DEF0);
    send_good(8'h00, 5);
    status("gap", 1, 0, 0, 0);
    drain("gap");

    // Reset on the 2nd byte of word 1: only word 0 is written.
    pulse_start();
    push(32'h0, 32'h1234_5678);
    for (int i = 0; i < 7; i++) send_byte(GOOD[i], 0, 1'b0);
    send_byte(8'hBC, 0, 1'b1);
    status("midrst", 0, 0, 1, 0);
    drain("midrst");

    // start with rx_valid in IDLE: byte 55 must not be taken.
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    chk("idle_start_rx_ready", {31'd0, rx_ready}, 32'd1);
    push(32'h0, 32'h1234_5678);
    push(32'h4, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) send_byte(GOOD[i], 0, 1'b0);
    pulse_start(); // ignored mid-word
    for (int i = 5; i < 10; i++) send_byte(GOOD[i], 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    status("idlestart", 1, 0, 0, 0);
    drain("idlestart");

    // Reset in the cycle the 4th byte of word 0 is accepted: no write.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b1);
    status("rst4th", 0, 0, 1, 0);
    drain("rst4th");

    // Largest accepted count (256 words), last write at 0x3FC.
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    x = 8'h00;
    for (int k = 0; k < 256; k++) begin
      w = {8'(k), ~8'(k), 8'h5A, 8'(k) ^ 8'h3C};
      push(32'(k) * 32'd4, w);
      for (int j = 3; j >= 0; j--) begin
        x = x ^ w[j*8 +: 8];
        send_byte(w[j*8 +: 8], 0, 1'b0);
      end
    end
    send_byte(x, 0, 1'b0);
    status("max", 1, 0, 0, 0);
    drain("max");
    chk("max_last_addr", imem_wr_addr, 32'h3FC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
